// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and defaults for the direct-mapped data cache controller
package dcache_pkg;
    localparam int DEF_BLOCK_SIZE = 10;
    localparam int DEF_DATA_SIZE  = 32;
    localparam int DEF_INDEX_SIZE = 5;
    localparam int CNT_W          = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_REFILL = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;
endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - tag/valid/data storage with single-cycle flush
module dcache_array #(
    parameter int INDEX_SIZE = 5,
    parameter int TAG_SIZE   = 5,
    parameter int DATA_SIZE  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [INDEX_SIZE-1:0] idx,
    input  logic                  fill,
    input  logic                  update,
    input  logic [TAG_SIZE-1:0]   wr_tag,
    input  logic [DATA_SIZE-1:0]  wr_data,
    output logic                  rd_valid,
    output logic [TAG_SIZE-1:0]   rd_tag,
    output logic [DATA_SIZE-1:0]  rd_data
);
    localparam int ROWS = 2 ** INDEX_SIZE;

    logic [ROWS-1:0]      valid_q;
    logic [TAG_SIZE-1:0]  tag_q  [ROWS];
    logic [DATA_SIZE-1:0] data_q [ROWS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[idx] <= 1'b1;
        end
    end

    // Tag and data contents survive reset; only the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[idx]  <= wr_tag;
            data_q[idx] <= wr_data;
        end else if (update) begin
            data_q[idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];
endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through/no-write-allocate cache FSM and statistics
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int DATA_SIZE  = DEF_DATA_SIZE,
    parameter int INDEX_SIZE = DEF_INDEX_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [BLOCK_SIZE-1:0] cpu_addr,
    input  logic [DATA_SIZE-1:0]  cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_rvalid,
    output logic [DATA_SIZE-1:0]  cpu_rdata,
    output logic                  cpu_wack,
    input  logic                  flush,
    output logic [BLOCK_SIZE-1:0] mem_rdAddr,
    output logic                  mem_rdEn,
    input  logic [DATA_SIZE-1:0]  mem_data,
    output logic [BLOCK_SIZE-1:0] mem_wrAddr,
    output logic [DATA_SIZE-1:0]  mem_wrData,
    output logic                  mem_wrEn,
    output logic [CNT_W-1:0]      hit_cnt,
    output logic [CNT_W-1:0]      miss_cnt
);
    localparam int TAG_SIZE = BLOCK_SIZE - INDEX_SIZE;

    state_t                state_q, state_d;
    logic [BLOCK_SIZE-1:0] addr_q;
    logic                  we_q;
    logic [DATA_SIZE-1:0]  wdata_q;
    logic [DATA_SIZE-1:0]  rdata_q;
    logic [CNT_W-1:0]      hit_q, miss_q;

    logic                  accept, hit, arr_flush, fill, update;
    logic [INDEX_SIZE-1:0] idx;
    logic [TAG_SIZE-1:0]   tag;
    logic                  rd_valid;
    logic [TAG_SIZE-1:0]   rd_tag;
    logic [DATA_SIZE-1:0]  rd_data;
    logic [DATA_SIZE-1:0]  arr_wdata;

    assign idx       = addr_q[INDEX_SIZE-1:0];
    assign tag       = addr_q[BLOCK_SIZE-1:INDEX_SIZE];
    assign hit       = rd_valid && (rd_tag == tag);
    assign cpu_ready = (state_q == S_IDLE) && !flush;
    assign accept    = cpu_req && cpu_ready;
    assign arr_flush = (state_q == S_IDLE) && flush;
    assign fill      = (state_q == S_REFILL);
    assign update    = (state_q == S_WRITE) && hit;
    assign arr_wdata = fill ? mem_data : wdata_q;

    dcache_array #(
        .INDEX_SIZE(INDEX_SIZE),
        .TAG_SIZE  (TAG_SIZE),
        .DATA_SIZE (DATA_SIZE)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .flush   (arr_flush),
        .idx     (idx),
        .fill    (fill),
        .update  (update),
        .wr_tag  (tag),
        .wr_data (arr_wdata),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_LOOKUP;
            S_LOOKUP: begin
                if (we_q)     state_d = S_WRITE;
                else if (hit) state_d = S_RESP;
                else          state_d = S_REFILL;
            end
            S_REFILL: state_d = S_RESP;
            S_WRITE:  state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= cpu_addr;
                we_q    <= cpu_we;
                wdata_q <= cpu_wdata;
            end
            if (state_q == S_LOOKUP && !we_q && hit) begin
                rdata_q <= rd_data;
            end else if (state_q == S_REFILL) begin
                rdata_q <= mem_data;
            end
            // Both reads and writes are classified when leaving LOOKUP.
            if (state_q == S_LOOKUP) begin
                if (hit && hit_q != {CNT_W{1'b1}}) begin
                    hit_q <= hit_q + 1'b1;
                end else if (!hit && miss_q != {CNT_W{1'b1}}) begin
                    miss_q <= miss_q + 1'b1;
                end
            end
        end
    end

    assign cpu_rvalid = (state_q == S_RESP) && !we_q;
    assign cpu_wack   = (state_q == S_RESP) && we_q;
    assign cpu_rdata  = rdata_q;

    assign mem_rdEn   = (state_q == S_REFILL);
    assign mem_rdAddr = mem_rdEn ? addr_q : '0;
    assign mem_wrEn   = (state_q == S_WRITE);
    assign mem_wrAddr = mem_wrEn ? addr_q : '0;
    assign mem_wrData = mem_wrEn ? wdata_q : '0;

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have parameter BLOCK_SIZE, default 10, word-address width.
REQ-002 The block SHALL have parameter DATA_SIZE, default 32, data word width.
REQ-003 The block SHALL have parameter INDEX_SIZE, default 5, cache index width; TAG_SIZE = BLOCK_SIZE-INDEX_SIZE and CACHE_ROWS = 2**INDEX_SIZE are derived.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-006 The block SHALL have cpu_req input 1 (request), cpu_we input 1 (1=write), cpu_addr input BLOCK_SIZE, and cpu_wdata input DATA_SIZE.
REQ-007 The block SHALL have cpu_ready output 1 (request accepted this cycle if cpu_req), cpu_rvalid output 1 (read data valid), cpu_rdata output DATA_SIZE, and cpu_wack output 1 (write complete).
REQ-008 The block SHALL have flush input 1, which invalidates all lines.
REQ-009 The block SHALL have mem_rdAddr output BLOCK_SIZE, mem_rdEn output 1, and mem_data input DATA_SIZE (combinational read data from backing memory).
REQ-010 The block SHALL have mem_wrAddr output BLOCK_SIZE, mem_wrData output DATA_SIZE, and mem_wrEn output 1 (write on next clk edge).
REQ-011 The block SHALL have hit_cnt output 16 and miss_cnt output 16, saturating statistics counters.

Function
REQ-012 The controller SHALL be direct-mapped and write-through/no-write-allocate, with one DATA_SIZE word per line: index = addr[INDEX_SIZE-1:0], tag = addr[BLOCK_SIZE-1:INDEX_SIZE].
REQ-013 The FSM SHALL have states IDLE, LOOKUP, REFILL, WRITE and RESP.
REQ-014 cpu_ready SHALL equal (state==IDLE && !flush); a request SHALL be accepted in a cycle with cpu_req && cpu_ready; addr/we/wdata SHALL be registered and the next state SHALL be LOOKUP.
REQ-015 LOOKUP, read hit (valid && tag match) SHALL go to RESP with the line data captured; read miss SHALL go to REFILL; any write SHALL go to WRITE.
REQ-016 REFILL SHALL last one cycle: mem_rdEn=1, mem_rdAddr=registered addr; mem_data SHALL be written into the line (data, tag, valid=1) and captured for response at cycle end, then go to RESP.
REQ-017 WRITE SHALL last one cycle: mem_wrEn=1, mem_wrAddr/mem_wrData=registered addr/wdata; on a hit the line data SHALL be updated at the same edge; on a miss the array SHALL be left unchanged; then go to RESP.
REQ-018 RESP SHALL last one cycle: cpu_rvalid=1 with cpu_rdata for reads, or cpu_wack=1 for writes; then go to IDLE.
REQ-019 Latency from accept cycle C SHALL be: read hit rvalid at C+2; read miss rvalid at C+3; write wack at C+3; cpu_ready SHALL be high again at C+3 / C+4 / C+4 respectively.
REQ-020 cpu_rdata SHALL hold its last value outside RESP; cpu_rvalid and cpu_wack SHALL be single-cycle pulses.
REQ-021 mem_rdEn and mem_wrEn SHALL be 0 outside REFILL/WRITE, and mem addresses/data SHALL be 0 when their enable is low.
REQ-022 flush SHALL be sampled only in IDLE and take priority over cpu_req: all valid bits cleared at that edge, no request accepted; flush in other states SHALL be ignored.
REQ-023 hit_cnt/miss_cnt SHALL increment on LOOKUP exit (reads and writes both classified), and each SHALL saturate at 16'hFFFF.

Reset
REQ-024 On rst low, the block SHALL immediately enter IDLE, clear all valid bits, clear counters, and drive cpu_rvalid, cpu_wack, mem_rdEn, mem_wrEn, addresses, and cpu_rdata to 0.
REQ-025 Reset mid-operation SHALL abort the transaction with no memory write issued; the tag/data arrays SHALL NOT be reset.

Structure
REQ-026 Package dcache_pkg SHALL hold the state enum, default BLOCK_SIZE/DATA_SIZE/INDEX_SIZE, and the counter width constant (16).
REQ-027 Tag/valid/data storage with a single-cycle flush SHALL be a sub-module dcache_array; FSM and counters SHALL stay in dcache_ctrl.

Verification
REQ-028 Cold read of addr 10'h045 with mem[0x045]=32'hDEADBEEF -> mem_rdEn at C+2, rvalid at C+3 with DEADBEEF, miss_cnt=1.
REQ-029 Repeat read of 10'h045 -> rvalid at C+2 with DEADBEEF, no mem_rdEn, hit_cnt=1.
REQ-030 Write 32'h12345678 to 10'h045, then read -> mem_wrEn at C+2 with addr 045, wack at C+3; read hits and returns 12345678.
REQ-031 Read 10'h065 (same index 5, different tag) after 045 -> miss, refill, and a subsequent read of 045 misses.
REQ-032 Flush in IDLE asserted together with cpu_req -> cpu_ready=0 that cycle, request not accepted; next read of 045 misses.
REQ-033 rst low during REFILL and WRITE -> FSM in IDLE, no mem_wrEn pulse, counters 0; counters saturate at 16'hFFFF after 65536+ hits (forced).
